scan_sel_gen: RTL and testbench

Sequential select generator that sits directly upstream of the team's 2-to-4 decoder. It drives the decoder's 2-bit select input (A1/A0 as sel[1:0]) so the decoder's one-hot outputs step through the four positions, for example the digits of a multiplexed display. A prescaler sets the dwell time per position, and a mask skips unused positions. The block runs either continuously or as a single sweep with a start/done handshake.

---
 rtl/scan_sel_gen.sv | 134 +++++++++++++
 tb/tb_scan_sel_gen.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sel_gen.sv
// scan_sel_gen: sequential select generator feeding a 2-to-4 decoder.
// Steps sel through the positions enabled in mask, holding each one for
// DIV clock cycles. It runs either continuously or as one low-to-high
// sweep with a start/done handshake.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous reset, active-high
//   en     - run enable; low returns the block to idle
//   mode   - 0 = continuous scan, 1 = single sweep (sampled in idle only)
//   start  - sweep request (sampled in idle with mode=1)
//   mask   - per-position enable, bit i enables position i
//   sel    - decoder select (sel[1]=A1, sel[0]=A0)
//   valid  - sel is meaningful
//   tick   - one-cycle pulse when sel takes a new position value
//   busy   - high while a sweep is running
//   done   - one-cycle pulse when a sweep completes normally
module scan_sel_gen #(
  parameter int unsigned DIV = 4,
  parameter int unsigned CW  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic       start,
  input  logic [3:0] mask,
  output logic [1:0] sel,
  output logic       valid,
  output logic       tick,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONT  = 2'd1;
  localparam logic [1:0] ST_SWEEP = 2'd2;

  localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 1);

  logic [1:0]    state;
  logic [CW-1:0] pre;
  logic [3:0]    upper;
  logic [1:0]    first_sel;
  logic [1:0]    next_sel;
  logic          wrap;
  logic          advance;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] r;
    if (m[0])      r = 2'd0;
    else if (m[1]) r = 2'd1;
    else if (m[2]) r = 2'd2;
    else           r = 2'd3;
    return r;
  endfunction

  // Enabled positions strictly above the current one; empty means the
  // next step wraps back to the lowest enabled position.
  always_comb begin
    upper     = mask & (4'b1110 << sel);
    first_sel = lowest(mask);
    wrap      = (upper == '0);
    next_sel  = wrap ? first_sel : lowest(upper);
    advance   = (pre == PRE_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sel   <= '0;
      valid <= 1'b0;
      tick  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pre   <= '0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          pre   <= '0;
          if (en && (mask != '0)) begin
            if (!mode) begin
              state <= ST_CONT;
              sel   <= first_sel;
              valid <= 1'b1;
              tick  <= 1'b1;
            end else if (start) begin
              state <= ST_SWEEP;
              sel   <= first_sel;
              valid <= 1'b1;
              busy  <= 1'b1;
              tick  <= 1'b1;
            end
          end
        end

        ST_CONT, ST_SWEEP: begin
          if (!en || (mask == '0)) begin
            state <= ST_IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            pre   <= '0;
          end else if (advance) begin
            pre <= '0;
            // A sweep ends when there is no higher enabled position left.
            if ((state == ST_SWEEP) && wrap) begin
              state <= ST_IDLE;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              sel  <= next_sel;
              tick <= 1'b1;
            end
          end else begin
            pre <= pre + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          pre   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Testbench for scan_sel_gen: four instances with DIV = 1..4 share the
// same inputs; a dwell-countdown reference model predicts every output.
module tb_scan_sel_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic       start;
  logic [3:0] mask;

  // Per instance g: bits [g*6 +: 6] = {sel[1:0], valid, tick, busy, done}
  logic [23:0] dut_all;

  int errors;
  int checks;
  int cyc;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [1:0] sel;
    logic       valid;
    logic       tick;
    logic       busy;
    logic       done;

    scan_sel_gen #(.DIV(g + 1), .CW(16)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .mode (mode),
      .start(start),
      .mask (mask),
      .sel  (sel),
      .valid(valid),
      .tick (tick),
      .busy (busy),
      .done (done)
    );

    assign dut_all[g*6 +: 6] = {sel, valid, tick, busy, done};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: run 0 = stopped, 1 = continuous, 2 = sweep.
  // left counts the cycles still to be spent on the current position.
  int              run  [4];
  int              left [4];
  logic [3:0][1:0] m_sel;
  logic [3:0]      m_valid;
  logic [3:0]      m_tick;
  logic [3:0]      m_busy;
  logic [3:0]      m_done;

  function automatic logic [1:0] low_pos(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[2'(i)]) return 2'(i);
    end
    return 2'd0;
  endfunction

  task automatic model_step();
    for (int j = 0; j < 4; j++) begin
      logic [1:0] k;
      int         div;
      int         p;
      k   = 2'(j);
      div = j + 1;
      if (rst) begin
        run[k] = 0; left[k] = 0; m_sel[k] = 2'd0;
        m_valid[k] = 1'b0; m_tick[k] = 1'b0; m_busy[k] = 1'b0; m_done[k] = 1'b0;
      end else begin
        m_tick[k] = 1'b0;
        m_done[k] = 1'b0;
        if (run[k] == 0) begin
          m_valid[k] = 1'b0;
          m_busy[k]  = 1'b0;
          if (en && mask != 4'd0 && (!mode || start)) begin
            run[k]     = mode ? 2 : 1;
            m_sel[k]   = low_pos(mask);
            left[k]    = div;
            m_valid[k] = 1'b1;
            m_busy[k]  = mode;
            m_tick[k]  = 1'b1;
          end
        end else if (!en || mask == 4'd0) begin
          run[k]     = 0;
          m_valid[k] = 1'b0;
          m_busy[k]  = 1'b0;
        end else begin
          left[k] = left[k] - 1;
          if (left[k] == 0) begin
            // Walk upward from the current position; p >= 4 means wrapped.
            p = int'(m_sel[k]) + 1;
            while (!mask[2'(p % 4)]) p++;
            if (run[k] == 2 && p >= 4) begin
              run[k]     = 0;
              m_valid[k] = 1'b0;
              m_busy[k]  = 1'b0;
              m_done[k]  = 1'b1;
            end else begin
              m_sel[k]  = 2'(p % 4);
              left[k]   = div;
              m_tick[k] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  function automatic logic [5:0] m6(input logic [1:0] k);
    return {m_sel[k], m_valid[k], m_tick[k], m_busy[k], m_done[k]};
  endfunction

  function automatic logic [23:0] mdl_vec();
    return {m6(2'd3), m6(2'd2), m6(2'd1), m6(2'd0)};
  endfunction

  // Advance model and DUTs by one clock; outputs sampled 1 time unit later.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_idle();
    en    = 1'b0;
    start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b0; start = 1'b0; mask = 4'hF;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (dut_all !== 24'h0) begin
        errors++;
        $display("FAIL reset_values cyc=%0d got=%h want=%h", cyc, dut_all, 24'h0);
      end
      checks++;
      if (dut_all !== mdl_vec()) begin
        errors++;
        $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, dut_all, mdl_vec());
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_cont_full();
    logic [5:0] e;
    en = 1'b1; mode = 1'b0; start = 1'b0; mask = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      step();
      checks++;
      if (dut_all !== mdl_vec()) begin
        errors++;
        $display("FAIL cont_full_model cyc=%0d got=%h want=%h", cyc, dut_all, mdl_vec());
      end
      e = {2'(((c - 1) / 4) % 4), 1'b1, 1'(((c - 1) % 4) == 0), 2'b00};
      checks++;
      if (dut_all[23:18] !== e) begin
        errors++;
        $display("FAIL cont_full_div4 cyc=%0d got=%b want=%b", cyc, dut_all[23:18], e);
      end
    end
  endtask

  task automatic test_cont_mask();
    logic [5:0] e;
    go_idle();
    en = 1'b1; mode = 1'b0; mask = 4'b1010;
    for (int c = 1; c <= 16; c++) begin
      step();
      checks++;
      if (dut_all !== mdl_vec()) begin
        errors++;
        $display("FAIL cont_mask_model cyc=%0d got=%h want=%h", cyc, dut_all, mdl_vec());
      end
      e = {((((c - 1) / 4) % 2) != 0) ? 2'd3 : 2'd1, 1'b1, 1'(((c - 1) % 4) == 0), 2'b00};
      checks++;
      if (dut_all[23:18] !== e) begin
        errors++;
        $display("FAIL cont_mask_div4 cyc=%0d got=%b want=%b", cyc, dut_all[23:18], e);
      end
    end
  endtask

  task automatic test_sweep();
    logic [5:0] e;
    go_idle();
    en = 1'b1; mode = 1'b1; mask = 4'b0111;
    for (int c = 1; c <= 14; c++) begin
      start = (c == 1 || c == 3);
      step();
      checks++;
      if (dut_all !== mdl_vec()) begin
        errors++;
        $display("FAIL sweep_model cyc=%0d got=%h want=%h", cyc, dut_all, mdl_vec());
      end
      if (c <= 6)
        e = {2'((c - 1) / 2), 1'b1, 1'(((c - 1) % 2) == 0), 1'b1, 1'b0};
      else if (c == 7)
        e = 6'b10_0001;
      else
        e = 6'b10_0000;
      checks++;
      if (dut_all[11:6] !== e) begin
        errors++;
        $display("FAIL sweep_div2 cyc=%0d got=%b want=%b", cyc, dut_all[11:6], e);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_abort_en();
    go_idle();
    en = 1'b1; mode = 1'b1; mask = 4'b1111;
    for (int c = 1; c <= 7; c++) begin
      start = (c == 1);
      if (c == 7) en = 1'b0;
      step();
      checks++;
      if (dut_all !== mdl_vec()) begin
        errors++;
        $display("FAIL abort_en_model cyc=%0d got=%h want=%h", cyc, dut_all, mdl_vec());
      end
    end
    checks++;
    if (dut_all[17:12] !== 6'b01_0000) begin
      errors++;
      $display("FAIL abort_en_div3 cyc=%0d got=%b want=%b", cyc, dut_all[17:12], 6'b01_0000);
    end
    en = 1'b1; mask = 4'b0000; start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({dut_all[21], dut_all[15], dut_all[9], dut_all[3],
           dut_all[19], dut_all[13], dut_all[7], dut_all[1]} !== 8'h00) begin
        errors++;
        $display("FAIL mask0_idle cyc=%0d got=%h want=0", cyc, dut_all);
      end
      checks++;
      if (dut_all !== mdl_vec()) begin
        errors++;
        $display("FAIL mask0_model cyc=%0d got=%h want=%h", cyc, dut_all, mdl_vec());
      end
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    go_idle();
    en = 1'b1; mode = 1'b1; mask = 4'b0001; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++;
      if (dut_all !== mdl_vec()) begin
        errors++;
        $display("FAIL b2b_model cyc=%0d got=%h want=%h", cyc, dut_all, mdl_vec());
      end
      e = ((c % 2) == 1) ? 6'b00_1110 : 6'b00_0001;
      checks++;
      if (dut_all[5:0] !== e) begin
        errors++;
        $display("FAIL b2b_div1 cyc=%0d got=%b want=%b", cyc, dut_all[5:0], e);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_div1_rst();
    go_idle();
    en = 1'b1; mode = 1'b0; mask = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (dut_all[5:0] !== 6'b10_1100) begin
        errors++;
        $display("FAIL div1_cont cyc=%0d got=%b want=%b", cyc, dut_all[5:0], 6'b10_1100);
      end
      checks++;
      if (dut_all !== mdl_vec()) begin
        errors++;
        $display("FAIL div1_model cyc=%0d got=%h want=%h", cyc, dut_all, mdl_vec());
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if (dut_all !== 24'h0) begin
      errors++;
      $display("FAIL midrun_reset cyc=%0d got=%h want=%h", cyc, dut_all, 24'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 49) == 0);
      en    = ($urandom_range(0, 19) != 0);
      mode  = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0)
        mask = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom);
      step();
      checks++;
      if (dut_all !== mdl_vec()) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, dut_all, mdl_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    rst    = 1'b1;
    en     = 1'b0;
    mode   = 1'b0;
    start  = 1'b0;
    mask   = 4'd0;
    for (int j = 0; j < 4; j++) begin
      run[j]  = 0;
      left[j] = 0;
    end
    m_sel   = '0;
    m_valid = '0;
    m_tick  = '0;
    m_busy  = '0;
    m_done  = '0;

    test_reset();
    test_cont_full();
    test_cont_mask();
    test_sweep();
    test_abort_en();
    test_back_to_back();
    test_div1_rst();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
